pool_max_3x3: RTL and testbench

- Downstream consumer of the command/scheduling block's `pool_ready_3x3` / `im_3x3` outputs (op_type 011, POOLING_3x3_MAX).
- Latches one 3x3 window of FP16 activations and reduces it to its maximum with a sequential comparator.
- Returns the result with `pool_valid_3x3` and holds it until the scheduler withdraws ready.
- One instance serves one pooling window at a time.

---
 rtl/pool_max_3x3.sv | 163 ++++++++++++++++
 tb/tb_pool_max_3x3.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pool_max_3x3.sv
`default_nettype none
// ============================================================================
// pool_max_3x3 : 3x3 FP16 max-pooling reducer, LANES elements per cycle.
// Optional NaN propagation under macro POOL_NAN_PROP_EN.        Rev 1.0
// ============================================================================
module pool_max_3x3 #(
  parameter int KERNEL_ELEMS = 9,
  parameter int LANES        = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pool_ready_3x3,
  input  logic [143:0] im_3x3,
  output logic         pool_valid_3x3,
  output logic [15:0]  pool_out,
  output logic [3:0]   pool_idx,
  output logic         busy
);

  localparam logic [15:0] NEG_INF = 16'hFC00;

  generate
    if ((LANES != 1 && LANES != 3 && LANES != 9) || KERNEL_ELEMS != 9) begin : g_param_check
      $error("pool_max_3x3: LANES must be 1, 3 or 9 and KERNEL_ELEMS must be 9");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t        state;
  logic [143:0]  window;
  logic [3:0]    count;
  logic [15:0]   run_max;
  logic [3:0]    run_idx;
  logic [15:0]   nxt_max;
  logic [3:0]    nxt_idx;
  logic [15:0]   fin_out;
  logic [3:0]    fin_idx;
  logic          last_group;

  function automatic logic [15:0] elem_at(input logic [143:0] w, input logic [3:0] i);
    return w[143 - 16*int'(i) -: 16];
  endfunction

  // Sign-magnitude greater-than; +0 and -0 compare equal.
  function automatic logic fp16_gt(input logic [15:0] c, input logic [15:0] m);
    logic gt;
    case ({c[15], m[15]})
      2'b00:   gt = c[14:0] > m[14:0];
      2'b11:   gt = c[14:0] < m[14:0];
      2'b01:   gt = (c[14:0] != 15'd0) || (m[14:0] != 15'd0);
      default: gt = 1'b0;
    endcase
    return gt;
  endfunction

  always_comb begin
    nxt_max = run_max;
    nxt_idx = run_idx;
    for (int l = 0; l < LANES; l++) begin
      if (fp16_gt(elem_at(window, count + 4'(l)), nxt_max)) begin
        nxt_max = elem_at(window, count + 4'(l));
        nxt_idx = count + 4'(l);
      end
    end
  end

  assign last_group = (int'(count) + LANES) >= KERNEL_ELEMS;

`ifdef POOL_NAN_PROP_EN
  localparam logic [15:0] QNAN = 16'h7E00;

  logic       nan_seen;
  logic [3:0] nan_idx;
  logic       nxt_nan;
  logic [3:0] nxt_nan_idx;

  always_comb begin
    nxt_nan     = nan_seen;
    nxt_nan_idx = nan_idx;
    for (int l = 0; l < LANES; l++) begin
      if (!nxt_nan && elem_at(window, count + 4'(l)) ==? 16'b?111_11??_????_????
          && elem_at(window, count + 4'(l)) ==? 16'b????_????_????_???? 
          && (elem_at(window, count + 4'(l)) & 16'h03FF) != 16'h0000) begin
        nxt_nan     = 1'b1;
        nxt_nan_idx = count + 4'(l);
      end
    end
  end

  assign fin_out = nxt_nan ? QNAN : nxt_max;
  assign fin_idx = nxt_nan ? nxt_nan_idx : nxt_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nan_seen <= 1'b0;
      nan_idx  <= 4'd0;
    end else if (state == IDLE && pool_ready_3x3) begin
      nan_seen <= 1'b0;
      nan_idx  <= 4'd0;
    end else if (state == COMPARE) begin
      nan_seen <= nxt_nan;
      nan_idx  <= nxt_nan_idx;
    end
  end
`else
  assign fin_out = nxt_max;
  assign fin_idx = nxt_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      window         <= '0;
      count          <= 4'd0;
      run_max        <= 16'h0000;
      run_idx        <= 4'd0;
      pool_valid_3x3 <= 1'b0;
      pool_out       <= 16'h0000;
      pool_idx       <= 4'd0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pool_ready_3x3) begin
            window  <= im_3x3;
            run_max <= NEG_INF;
            run_idx <= 4'd0;
            count   <= 4'd0;
            busy    <= 1'b1;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          run_max <= nxt_max;
          run_idx <= nxt_idx;
          count   <= count + 4'(LANES);
          if (last_group) begin
            pool_out       <= fin_out;
            pool_idx       <= fin_idx;
            pool_valid_3x3 <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          // Leaving only on ready low keeps one window from being pooled twice.
          if (!pool_ready_3x3) begin
            pool_valid_3x3 <= 1'b0;
            busy           <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool_max_3x3.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for pool_max_3x3: serial (LANES=1) and grouped (LANES=3) instances.
module tb_pool_max_3x3;

  logic         clk = 1'b0;
  logic         rst;
  logic         ready1, ready3;
  logic [143:0] im;
  logic         valid1, valid3, busy1, busy3;
  logic [15:0]  out1, out3;
  logic [3:0]   idx1, idx3;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [15:0] out;
    logic [3:0]  idx;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  logic prev1 = 1'b0;
  logic prev3 = 1'b0;

  always #5 clk = ~clk;

  pool_max_3x3 #(.KERNEL_ELEMS(9), .LANES(1)) dut1 (
    .clk(clk), .rst(rst), .pool_ready_3x3(ready1), .im_3x3(im),
    .pool_valid_3x3(valid1), .pool_out(out1), .pool_idx(idx1), .busy(busy1)
  );

  pool_max_3x3 #(.KERNEL_ELEMS(9), .LANES(3)) dut3 (
    .clk(clk), .rst(rst), .pool_ready_3x3(ready3), .im_3x3(im),
    .pool_valid_3x3(valid3), .pool_out(out3), .pool_idx(idx3), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: map sign-magnitude to a signed integer so +0 == -0.
  function automatic int fval(input logic [15:0] x);
    return x[15] ? -int'(x[14:0]) : int'(x[14:0]);
  endfunction

  function automatic exp_t model(input logic [143:0] w);
    exp_t        r;
    int          best;
    logic [15:0] e;
    bit          nan_seen;
    logic [3:0]  nan_i;
    best     = fval(16'hFC00);
    r.out    = 16'hFC00;
    r.idx    = 4'd0;
    nan_seen = 1'b0;
    nan_i    = 4'd0;
    for (int i = 0; i < 9; i++) begin
      e = w[143 - 16*i -: 16];
      if (fval(e) > best) begin
        best  = fval(e);
        r.out = e;
        r.idx = 4'(i);
      end
      if (!nan_seen && e[14:10] == 5'h1F && e[9:0] != 10'd0) begin
        nan_seen = 1'b1;
        nan_i    = 4'(i);
      end
    end
`ifdef POOL_NAN_PROP_EN
    if (nan_seen) begin
      r.out = 16'h7E00;
      r.idx = nan_i;
    end
`endif
    return r;
  endfunction

  function automatic logic cur_valid(input int sel);
    return (sel == 1) ? valid1 : valid3;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 1) ? busy1 : busy3;
  endfunction

  always @(negedge clk) begin
    if (valid1 && !prev1) begin
      if (q1.size() == 0) check("spurious_valid_l1", 32'(valid1), 32'd0);
      else begin
        e1 = q1.pop_front();
        check("out_l1", 32'(out1), 32'(e1.out));
        check("idx_l1", 32'(idx1), 32'(e1.idx));
      end
    end
    prev1 = valid1;
    if (valid3 && !prev3) begin
      if (q3.size() == 0) check("spurious_valid_l3", 32'(valid3), 32'd0);
      else begin
        e3 = q3.pop_front();
        check("out_l3", 32'(out3), 32'(e3.out));
        check("idx_l3", 32'(idx3), 32'(e3.idx));
      end
    end
    prev3 = valid3;
  end

  task automatic set_ready(input int sel, input logic v);
    if (sel == 1) ready1 = v;
    else          ready3 = v;
  endtask

  // hold: cycles to keep ready after valid; drop_at: COMPARE cycle at which ready falls (0 = never)
  task automatic run_window(input logic [143:0] w, input int sel, input logic [15:0] eo,
                            input logic [3:0] ei, input int hold, input int drop_at);
    exp_t e;
    int   lat;
    int   hi;
    e.out = eo;
    e.idx = ei;
    @(negedge clk);
    im = w;
    if (sel == 1) q1.push_back(e);
    else          q3.push_back(e);
    set_ready(sel, 1'b1);
    @(negedge clk);
    im = {9{16'h7BFF}};
    lat = 0;
    while (!cur_valid(sel) && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == drop_at) set_ready(sel, 1'b0);
    end
    check(sel == 1 ? "latency_l1" : "latency_l3", 32'(lat), sel == 1 ? 32'd9 : 32'd3);
    hi = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (cur_valid(sel)) hi++;
    end
    if (hold > 0) check("valid_hold", 32'(hi), 32'(hold));
    set_ready(sel, 1'b0);
    @(negedge clk);
    check("valid_drop", 32'(cur_valid(sel)), 32'd0);
    check("busy_drop", 32'(cur_busy(sel)), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  localparam logic [15:0] POOL [12] = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h4000, 16'hC000,
                                         16'h7C00, 16'hFC00, 16'h3C00, 16'h0001, 16'h8001, 16'h7BFF};

  initial begin
    logic [143:0] w;
    exp_t         m;
    rst    = 1'b1;
    ready1 = 1'b0;
    ready3 = 1'b0;
    im     = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid1), 32'd0);
    check("rst_out",   32'(out1),   32'd0);
    check("rst_idx",   32'(idx1),   32'd0);
    check("rst_busy",  32'(busy1 | busy3), 32'd0);
    rst = 1'b0;

    w = {16'h3C00, 16'h4000, 16'hBC00, 16'h0000, 16'h3800, 16'hC000, 16'h3E00, 16'h0000, 16'h3400};
    run_window(w, 1, 16'h4000, 4'd1, 20, 0);
    run_window(w, 3, 16'h4000, 4'd1, 2, 0);

    w = {16'hBC00, 16'hC000, 16'hB800, 16'hC400, 16'hBE00, 16'hC200, 16'hBA00, 16'hC100, 16'hBD00};
    run_window(w, 1, 16'hB800, 4'd2, 1, 0);
    run_window(w, 3, 16'hB800, 4'd2, 1, 0);

    w = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_window(w, 1, 16'h0000, 4'd0, 1, 0);
    w = {16'h0000, 16'h0000, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3C00, 16'h0000};
    run_window(w, 1, 16'h3C00, 4'd2, 1, 0);
    run_window(w, 3, 16'h3C00, 4'd2, 1, 0);

    w = {{5{16'h3C00}}, 16'h7E00, {3{16'h3C00}}};
    run_window(w, 1, 16'h7E00, 4'd5, 1, 0);
    w = {16'h7C00, {4{16'h3C00}}, 16'h7E00, {3{16'h3C00}}};
    run_window(w, 1, 16'h7E00, 4'd5, 1, 0);
    run_window(w, 3, 16'h7E00, 4'd5, 1, 0);

    w = {16'h3C00, 16'h4000, 16'hBC00, 16'h0000, 16'h3800, 16'hC000, 16'h3E00, 16'h0000, 16'h3400};
    run_window(w, 1, 16'h4000, 4'd1, 0, 3);

    // Abort a window with reset in the middle of COMPARE.
    @(negedge clk);
    im     = {16'h4000, {8{16'h3C00}}};
    ready1 = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    check("busy_in_compare", 32'(busy1), 32'd1);
    rst    = 1'b1;
    ready1 = 1'b0;
    #1;
    check("abort_valid", 32'(valid1), 32'd0);
    check("abort_busy",  32'(busy1),  32'd0);
    check("abort_out",   32'(out1),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_idle", 32'(valid1 | busy1), 32'd0);
    w = {16'h3C00, 16'h4000, 16'hBC00, 16'h0000, 16'h3800, 16'hC000, 16'h3E00, 16'h0000, 16'h4400};
    run_window(w, 1, 16'h4400, 4'd8, 1, 0);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 9; i++) w[143 - 16*i -: 16] = POOL[$urandom_range(0, 11)];
      m = model(w);
      run_window(w, 1, m.out, m.idx, 1, 0);
      run_window(w, 3, m.out, m.idx, 1, 0);
    end

    check("queue_empty", 32'(q1.size() + q3.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
